keypad_scan_ctrl: RTL and testbench

// Scan controller for the 4x4 matrix keypad used for paddle input. It drives the

---
 rtl/keypad_scan_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: drives active-low rows, debounces full-matrix snapshots,
// and reports press/release keycode events through a small valid/ready FIFO.
module keypad_scan_ctrl #(
    parameter int SETTLE_CYCLES  = 512,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  cols,
    output logic [3:0]  rows,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [3:0]  ev_key,
    output logic        ev_press,
    output logic [15:0] key_state,
    output logic        overflow
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int CNT_W = (SET_W > 4) ? SET_W : 4;
    localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] EMIT_LAST   = CNT_W'(15);
    localparam logic [STB_W-1:0] DEB_THR     = STB_W'(DEBOUNCE_SCANS);
    localparam logic [AW:0]      DEPTH_V     = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_SCAN    = 2'd0,
        S_COMPARE = 2'd1,
        S_EMIT    = 2'd2
    } state_e;

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'd0:    code = 4'd1;
            4'd1:    code = 4'd2;
            4'd2:    code = 4'd3;
            4'd3:    code = 4'd10;
            4'd4:    code = 4'd4;
            4'd5:    code = 4'd5;
            4'd6:    code = 4'd6;
            4'd7:    code = 4'd11;
            4'd8:    code = 4'd7;
            4'd9:    code = 4'd8;
            4'd10:   code = 4'd9;
            4'd11:   code = 4'd12;
            4'd12:   code = 4'd14;
            4'd13:   code = 4'd0;
            4'd14:   code = 4'd15;
            4'd15:   code = 4'd13;
            default: code = 4'd0;
        endcase
        return code;
    endfunction

    function automatic logic [3:0] row_drive(input logic [1:0] row);
        return ~(4'b0001 << row);
    endfunction

    function automatic logic [STB_W-1:0] sat_inc(input logic [STB_W-1:0] v);
        logic [STB_W-1:0] r;
        if (v == {STB_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + STB_W'(1'b1);
        end
        return r;
    endfunction

    state_e           state_q, state_d;
    logic [1:0]       row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q;
    logic [3:0]       rows_q, rows_d;
    logic [15:0]      snap_q, snap_d;
    logic [15:0]      prev_q, prev_d;
    logic [STB_W-1:0] stb_q, stb_d, stb_new_s;
    logic [15:0]      key_state_q, key_state_d;
    logic             push_s;
    logic [4:0]       push_data_s;
    logic [3:0]       emit_key_s;

    logic [4:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      count_q, count_d;
    logic             pop_s, full_s, accept_s;
    logic             ev_valid_q, ev_valid_d;
    logic [3:0]       ev_key_q, ev_key_d;
    logic             ev_press_q, ev_press_d;
    logic             overflow_q, overflow_d;

    // Scan/compare/emit sequencing and debounce bookkeeping
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        cnt_d       = cnt_q;
        snap_d      = snap_q;
        prev_d      = prev_q;
        stb_d       = stb_q;
        key_state_d = key_state_q;
        push_s      = 1'b0;
        emit_key_s  = cnt_q[3:0];
        push_data_s = {emit_key_s, snap_q[emit_key_s]};
        stb_new_s   = (snap_q == prev_q) ? sat_inc(stb_q) : STB_W'(1'b1);
        case (state_q)
            S_SCAN: begin
                // The cycle right after reset idles with rows released so row 0 gets a full settle window.
                if (start_q) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == SETTLE_LAST) begin
                    for (int c = 0; c < 4; c++) begin
                        snap_d[key_code(row_q, c[1:0])] = ~cols[c];
                    end
                    cnt_d = {CNT_W{1'b0}};
                    if (row_q == 2'd3) begin
                        state_d = S_COMPARE;
                        row_d   = 2'd0;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1'b1);
                end
            end
            S_COMPARE: begin
                prev_d = snap_q;
                stb_d  = stb_new_s;
                cnt_d  = {CNT_W{1'b0}};
                if ((stb_new_s >= DEB_THR) && (snap_q != key_state_q)) begin
                    state_d = S_EMIT;
                end else begin
                    state_d = S_SCAN;
                end
            end
            S_EMIT: begin
                if (snap_q[emit_key_s] != key_state_q[emit_key_s]) begin
                    push_s                  = 1'b1;
                    key_state_d[emit_key_s] = snap_q[emit_key_s];
                end else begin
                    push_s = 1'b0;
                end
                if (cnt_q == EMIT_LAST) begin
                    state_d = S_SCAN;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1'b1);
                end
            end
            default: begin
                state_d = S_SCAN;
                row_d   = 2'd0;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
        rows_d = (state_d == S_SCAN) ? row_drive(row_d) : 4'b1111;
    end

    // Event FIFO pointers and registered head; a push into a full FIFO is accepted only alongside a pop
    always_comb begin
        pop_s      = ev_valid_q & ev_ready;
        full_s     = (count_q == DEPTH_V);
        accept_s   = push_s & (~full_s | pop_s);
        overflow_d = push_s & full_s & ~pop_s;
        wr_d       = wr_q;
        rd_d       = rd_q;
        count_d    = count_q;
        if (accept_s) begin
            wr_d = wr_q + AW'(1'b1);
        end else begin
            wr_d = wr_q;
        end
        if (pop_s) begin
            rd_d = rd_q + AW'(1'b1);
        end else begin
            rd_d = rd_q;
        end
        case ({accept_s, pop_s})
            2'b10:   count_d = count_q + (AW + 1)'(1'b1);
            2'b01:   count_d = count_q - (AW + 1)'(1'b1);
            default: count_d = count_q;
        endcase
        ev_valid_d = (count_d != (AW + 1)'(1'b0));
        if (accept_s && (wr_q == rd_d)) begin
            {ev_key_d, ev_press_d} = push_data_s;
        end else begin
            {ev_key_d, ev_press_d} = mem_q[rd_d];
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_SCAN;
            row_q       <= 2'd0;
            cnt_q       <= {CNT_W{1'b0}};
            start_q     <= 1'b1;
            rows_q      <= 4'b1111;
            snap_q      <= 16'h0000;
            prev_q      <= 16'h0000;
            stb_q       <= {STB_W{1'b0}};
            key_state_q <= 16'h0000;
            wr_q        <= {AW{1'b0}};
            rd_q        <= {AW{1'b0}};
            count_q     <= {(AW + 1){1'b0}};
            ev_valid_q  <= 1'b0;
            ev_key_q    <= 4'd0;
            ev_press_q  <= 1'b0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 5'd0;
            end
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            start_q     <= 1'b0;
            rows_q      <= rows_d;
            snap_q      <= snap_d;
            prev_q      <= prev_d;
            stb_q       <= stb_d;
            key_state_q <= key_state_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            count_q     <= count_d;
            ev_valid_q  <= ev_valid_d;
            ev_key_q    <= ev_key_d;
            ev_press_q  <= ev_press_d;
            overflow_q  <= overflow_d;
            if (accept_s) begin
                mem_q[wr_q] <= push_data_s;
            end
        end
    end

    assign rows      = rows_q;
    assign ev_valid  = ev_valid_q;
    assign ev_key    = ev_key_q;
    assign ev_press  = ev_press_q;
    assign key_state = key_state_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a behavioural 4x4 keypad model driving cols from rows.
module tb_keypad_scan_ctrl;

    localparam int KEYMAP [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic        ev_valid;
    logic        ev_ready;
    logic [3:0]  ev_key;
    logic        ev_press;
    logic [15:0] key_state;
    logic        overflow;

    logic [15:0] pressed;
    logic [4:0]  ev_q [$];
    int          ev_t [$];
    int          cyc = 0;
    int          ovf_cnt = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic        found;

    keypad_scan_ctrl #(
        .SETTLE_CYCLES (4),
        .DEBOUNCE_SCANS(2),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cols     (cols),
        .rows     (rows),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_key   (ev_key),
        .ev_press (ev_press),
        .key_state(key_state),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Keypad: a held key pulls its column low while its row is driven low
    always_comb begin
        cols = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!rows[r] && pressed[KEYMAP[r*4+c]]) cols[c] = 1'b0;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && ev_valid && ev_ready) begin
            ev_q.push_back({ev_key, ev_press});
            ev_t.push_back(cyc);
        end
        if (rst_n && overflow) ovf_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_ev(input string tag, input int idx, input logic [3:0] key, input logic press);
        logic [31:0] got;
        got = 32'hDEAD;
        if (idx < ev_q.size()) got = 32'(ev_q[idx]);
        check_eq(tag, got, 32'({key, press}));
    endtask

    // Called at the negedge where rst_n was just released
    task automatic check_scan(input string tag);
        logic [3:0] e;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            e = 4'b1111;
            if (i < 16) e[i/4] = 1'b0;
            else if (i == 17) e[0] = 1'b0;
            check_eq($sformatf("%s_rows%0d", tag, i), 32'(rows), 32'(e));
        end
    endtask

    task automatic clear_log();
        ev_q.delete();
        ev_t.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        ev_ready = 1'b1;
        pressed  = 16'h0000;

        // 1: reset values and idle scan pattern
        repeat (3) @(negedge clk);
        check_eq("t1_rst_rows", 32'(rows), 32'hF);
        check_eq("t1_rst_valid", 32'(ev_valid), 32'h0);
        check_eq("t1_rst_kstate", 32'(key_state), 32'h0);
        check_eq("t1_rst_ovf", 32'(overflow), 32'h0);
        rst_n = 1'b1;
        check_scan("t1");
        repeat (40) @(negedge clk);
        check_eq("t1_no_events", 32'(ev_q.size()), 32'd0);
        check_eq("t1_valid_idle", 32'(ev_valid), 32'h0);

        // 2: single key press then release
        clear_log();
        pressed = 16'h0020;
        repeat (150) @(negedge clk);
        check_eq("t2_press_cnt", 32'(ev_q.size()), 32'd1);
        check_ev("t2_press_ev", 0, 4'd5, 1'b1);
        check_eq("t2_press_kstate", 32'(key_state), 32'h0020);
        clear_log();
        pressed = 16'h0000;
        repeat (150) @(negedge clk);
        check_eq("t2_rel_cnt", 32'(ev_q.size()), 32'd1);
        check_ev("t2_rel_ev", 0, 4'd5, 1'b0);
        check_eq("t2_rel_kstate", 32'(key_state), 32'h0);

        // 3: key present only in alternate scans never debounces
        clear_log();
        for (int i = 0; i < 10; i++) begin
            found = 1'b0;
            for (int w = 0; w < 40; w++) begin
                @(negedge clk);
                if (rows == 4'b1111) begin
                    found = 1'b1;
                    break;
                end
            end
            check_eq($sformatf("t3_sync%0d", i), 32'(found), 32'h1);
            pressed = (i % 2 == 0) ? 16'h0020 : 16'h0000;
            @(negedge clk);
        end
        pressed = 16'h0000;
        repeat (60) @(negedge clk);
        check_eq("t3_no_events", 32'(ev_q.size()), 32'd0);
        check_eq("t3_kstate", 32'(key_state), 32'h0);

        // 4: two simultaneous keys emitted in ascending keycode order
        clear_log();
        pressed = 16'h2002;
        repeat (150) @(negedge clk);
        check_eq("t4_cnt", 32'(ev_q.size()), 32'd2);
        check_ev("t4_ev0", 0, 4'd1, 1'b1);
        check_ev("t4_ev1", 1, 4'd13, 1'b1);
        if (ev_t.size() == 2) check_eq("t4_gap", 32'(ev_t[1] - ev_t[0]), 32'd12);
        check_eq("t4_kstate", 32'(key_state), 32'h2002);
        clear_log();
        pressed = 16'h0000;
        repeat (150) @(negedge clk);
        check_eq("t4_rel_cnt", 32'(ev_q.size()), 32'd2);
        check_ev("t4_rel0", 0, 4'd1, 1'b0);
        check_ev("t4_rel1", 1, 4'd13, 1'b0);
        check_eq("t4_rel_kstate", 32'(key_state), 32'h0);

        // 5: stalled consumer, FIFO fills and overflows
        clear_log();
        ovf_cnt  = 0;
        ev_ready = 1'b0;
        pressed  = 16'h000E;
        repeat (150) @(negedge clk);
        check_eq("t5_press_kstate", 32'(key_state), 32'h000E);
        check_eq("t5_stall_valid", 32'(ev_valid), 32'h1);
        check_eq("t5_stall_head", 32'({ev_key, ev_press}), 32'({4'd1, 1'b1}));
        pressed = 16'h0000;
        repeat (150) @(negedge clk);
        check_eq("t5_rel_kstate", 32'(key_state), 32'h0);
        check_eq("t5_ovf_pulses", 32'(ovf_cnt), 32'd2);
        check_eq("t5_head_held", 32'({ev_key, ev_press}), 32'({4'd1, 1'b1}));
        check_eq("t5_none_popped", 32'(ev_q.size()), 32'd0);
        ev_ready = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("t5_drain_cnt", 32'(ev_q.size()), 32'd4);
        check_ev("t5_drain0", 0, 4'd1, 1'b1);
        check_ev("t5_drain1", 1, 4'd2, 1'b1);
        check_ev("t5_drain2", 2, 4'd3, 1'b1);
        check_ev("t5_drain3", 3, 4'd1, 1'b0);
        check_eq("t5_drained", 32'(ev_valid), 32'h0);

        // 6: reset asserted in the middle of an emit
        clear_log();
        ev_ready = 1'b0;
        pressed  = 16'h2006;
        found    = 1'b0;
        for (int w = 0; w < 150; w++) begin
            @(negedge clk);
            if (ev_valid) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("t6_emit_seen", 32'(found), 32'h1);
        repeat (2) @(negedge clk);
        check_eq("t6_mid_kstate", 32'(key_state), 32'h0006);
        rst_n   = 1'b0;
        pressed = 16'h0000;
        @(negedge clk);
        check_eq("t6_rst_valid", 32'(ev_valid), 32'h0);
        check_eq("t6_rst_kstate", 32'(key_state), 32'h0);
        check_eq("t6_rst_rows", 32'(rows), 32'hF);
        rst_n = 1'b1;
        check_scan("t6");
        repeat (60) @(negedge clk);
        check_eq("t6_after_valid", 32'(ev_valid), 32'h0);
        check_eq("t6_after_kstate", 32'(key_state), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
